// File: rtl/cache_data_stage_pkg.sv
// Shared widths, types and helpers for the registered cache data stage.
// Holds the line/word/mask typedefs, the store-buffer entry and offset alignment.
package cache_pkg;

  localparam int unsigned WAYS          = 4;
  localparam int unsigned SET_WIDTH     = 4;
  localparam int unsigned DATA_WIDTH    = 256;
  localparam int unsigned WORD_WIDTH    = 32;
  localparam int unsigned OFFSET_WIDTH  = 5;
  localparam int unsigned MASK_WIDTH    = DATA_WIDTH / 8;
  localparam int unsigned WMASK_WIDTH   = WORD_WIDTH / 8;
  localparam int unsigned WAY_WIDTH     = $clog2(WAYS);
  localparam int unsigned WORD_OFF_BITS = $clog2(WMASK_WIDTH);

  typedef logic [DATA_WIDTH-1:0]   line_t;
  typedef logic [WORD_WIDTH-1:0]   word_t;
  typedef logic [MASK_WIDTH-1:0]   lmask_t;
  typedef logic [WMASK_WIDTH-1:0]  wmask_t;
  typedef logic [SET_WIDTH-1:0]    set_t;
  typedef logic [WAY_WIDTH-1:0]    way_t;
  typedef logic [OFFSET_WIDTH-1:0] offset_t;

  typedef struct packed {
    logic   valid;
    set_t   set;
    way_t   way;
    line_t  line;
    lmask_t mask;
  } sb_entry_t;

  // Misaligned low offset bits are dropped rather than faulted.
  function automatic offset_t word_align(input offset_t offset);
    offset_t v_aligned;
    v_aligned = offset;
    v_aligned[WORD_OFF_BITS-1:0] = '0;
    return v_aligned;
  endfunction

endpackage

// File: rtl/cache_data_stage_if.sv
// Request/response and array-write signals between controller, array and data stage.
// The data stage takes the slave view; the controller/array side takes the master view.
interface cache_data_stage_if;
  import cache_pkg::*;

  logic    req_read;
  logic    req_write;
  set_t    req_set;
  way_t    req_way;
  offset_t req_offset;
  wmask_t  req_wmask;
  word_t   req_wdata;
  logic    hit;
  line_t   cache_data;
  logic    flush_req;

  logic    ufp_resp;
  word_t   ufp_rdata;
  logic    arr_we;
  set_t    arr_set;
  way_t    arr_way;
  lmask_t  arr_wmask;
  line_t   arr_wdata;
  logic    sb_valid;

  modport master (
    output req_read, req_write, req_set, req_way, req_offset, req_wmask, req_wdata,
    output hit, cache_data, flush_req,
    input  ufp_resp, ufp_rdata, arr_we, arr_set, arr_way, arr_wmask, arr_wdata, sb_valid
  );

  modport slave (
    input  req_read, req_write, req_set, req_way, req_offset, req_wmask, req_wdata,
    input  hit, cache_data, flush_req,
    output ufp_resp, ufp_rdata, arr_we, arr_set, arr_way, arr_wmask, arr_wdata, sb_valid
  );

endinterface

// File: rtl/cache_data_stage_line_byte_merge.sv
// Combinational merge of a byte-masked word into a line at an aligned offset.
// Also returns the word mask shifted into line byte positions.
module line_byte_merge
  import cache_pkg::*;
(
  input  line_t   i_line,
  input  offset_t i_offset,
  input  word_t   i_wdata,
  input  wmask_t  i_wmask,
  output line_t   o_line,
  output lmask_t  o_mask
);

  always_comb begin
    o_line = i_line;
    o_mask = '0;
    for (int b = 0; b < int'(WMASK_WIDTH); b++) begin
      if (i_wmask[b]) begin
        o_line[(int'(i_offset) + b) * 8 +: 8] = i_wdata[b * 8 +: 8];
        o_mask[int'(i_offset) + b]           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_data_stage.sv
// Registered cache data stage: one-cycle read/write hit responses with a
// one-entry coalescing store buffer that drains to the data array when idle.
module cache_data_stage
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cache_data_stage_if.slave stage_bus
);

  logic      w_accept;
  logic      w_is_read;
  logic      w_is_write;
  logic      w_match;
  logic      w_coalesce;
  logic      w_capture;
  logic      w_drain;
  offset_t   w_aoff;
  line_t     w_fwd_line;
  line_t     w_merge_base;
  line_t     w_merged_line;
  lmask_t    w_shift_mask;
  word_t     w_rd_word;
  word_t     w_rdata_next;
  sb_entry_t w_sb_next;

  sb_entry_t r_sb;
  logic      r_resp;
  word_t     r_rdata;

  // Read wins over a simultaneous write; misses are invisible to the stage.
  assign w_accept   = (stage_bus.req_read | stage_bus.req_write) & stage_bus.hit;
  assign w_is_read  = w_accept & stage_bus.req_read;
  assign w_is_write = w_accept & stage_bus.req_write & ~stage_bus.req_read;
  assign w_aoff     = word_align(stage_bus.req_offset);

  assign w_match    = r_sb.valid && (r_sb.set == stage_bus.req_set)
                                 && (r_sb.way == stage_bus.req_way);
  assign w_coalesce = w_is_write & w_match;
  assign w_capture  = w_is_write & (|stage_bus.req_wmask);

  // Drain is held off during reset so a discarded store never reaches the array.
  assign w_drain = r_sb.valid && (!stage_bus.req_read || stage_bus.flush_req)
                              && !w_coalesce && !rst;

  always_comb begin
    w_fwd_line = stage_bus.cache_data;
    for (int i = 0; i < int'(MASK_WIDTH); i++) begin
      if (w_match && r_sb.mask[i]) begin
        w_fwd_line[i * 8 +: 8] = r_sb.line[i * 8 +: 8];
      end
    end
  end

  assign w_rd_word    = w_fwd_line[int'(w_aoff) * 8 +: WORD_WIDTH];
  assign w_merge_base = w_match ? r_sb.line : stage_bus.cache_data;

  line_byte_merge u_merge (
    .i_line   (w_merge_base),
    .i_offset (w_aoff),
    .i_wdata  (stage_bus.req_wdata),
    .i_wmask  (stage_bus.req_wmask),
    .o_line   (w_merged_line),
    .o_mask   (w_shift_mask)
  );

  always_comb begin
    w_sb_next = r_sb;
    if (w_drain) begin
      w_sb_next.valid = 1'b0;
    end
    if (w_capture) begin
      w_sb_next.line = w_merged_line;
      if (w_match) begin
        w_sb_next.mask = r_sb.mask | w_shift_mask;
      end else begin
        w_sb_next.valid = 1'b1;
        w_sb_next.set   = stage_bus.req_set;
        w_sb_next.way   = stage_bus.req_way;
        w_sb_next.mask  = w_shift_mask;
      end
    end
  end

  assign w_rdata_next = w_is_read ? w_rd_word : r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb    <= '0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_sb    <= w_sb_next;
      r_resp  <= w_accept;
      r_rdata <= w_rdata_next;
    end
  end

  assign stage_bus.ufp_resp  = r_resp;
  assign stage_bus.ufp_rdata = r_rdata;
  assign stage_bus.arr_we    = w_drain;
  assign stage_bus.arr_set   = r_sb.set;
  assign stage_bus.arr_way   = r_sb.way;
  assign stage_bus.arr_wmask = r_sb.mask;
  assign stage_bus.arr_wdata = r_sb.line;
  assign stage_bus.sb_valid  = r_sb.valid;

endmodule

// File: tb/tb_cache_data_stage.sv
// Directed bench for cache_data_stage: reads, store buffering, forwarding,
// coalescing, reload, flush and reset discard.
module tb_cache_data_stage;
  import cache_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  cache_data_stage_if bus ();

  cache_data_stage dut (
    .clk       (clk),
    .rst       (rst),
    .stage_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  function automatic line_t put_word(input line_t l, input int off, input word_t w);
    line_t v;
    v = l;
    v[off * 8 +: 32] = w;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input set_t s, input way_t w,
                       input offset_t off, input word_t wd, input wmask_t wm,
                       input logic h, input line_t cl, input logic fl);
    bus.req_read   = rd;
    bus.req_write  = wr;
    bus.req_set    = s;
    bus.req_way    = w;
    bus.req_offset = off;
    bus.req_wdata  = wd;
    bus.req_wmask  = wm;
    bus.hit        = h;
    bus.cache_data = cl;
    bus.flush_req  = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.ufp_resp !== 1'b0) $display("FAIL reset_resp got %b exp 0", bus.ufp_resp); else n_pass++;
    n_checks++; if (bus.ufp_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", bus.ufp_rdata); else n_pass++;
    n_checks++; if (bus.sb_valid !== 1'b0) $display("FAIL reset_sb_valid got %b exp 0", bus.sb_valid); else n_pass++;
    n_checks++; if (bus.arr_we !== 1'b0) $display("FAIL reset_arr_we got %b exp 0", bus.arr_we); else n_pass++;
  endtask

  task automatic test_read_hit();
    line_t l1 = put_word('0, 8, 32'hDEADBEEF);
    line_t l2 = put_word('1, 8, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 4'd2, 2'd1, 5'd8, '0, '0, 1'b1, l1, 1'b0);
    n_checks++; if (bus.arr_we !== 1'b0) $display("FAIL read_arr_we got %b exp 0", bus.arr_we); else n_pass++;
    step();
    n_checks++; if (bus.ufp_resp !== 1'b1) $display("FAIL read_resp got %b exp 1", bus.ufp_resp); else n_pass++;
    n_checks++; if (bus.ufp_rdata !== 32'hDEADBEEF) $display("FAIL read_rdata got %h exp deadbeef", bus.ufp_rdata); else n_pass++;
    drive(1'b1, 1'b0, 4'd2, 2'd1, 5'd10, '0, '0, 1'b1, l2, 1'b0);
    step();
    n_checks++; if (bus.ufp_rdata !== 32'hCAFEF00D) $display("FAIL read_misaligned got %h exp cafef00d", bus.ufp_rdata); else n_pass++;
    idle();
    step();
    n_checks++; if (bus.ufp_resp !== 1'b0) $display("FAIL read_resp_pulse got %b exp 0", bus.ufp_resp); else n_pass++;
    n_checks++; if (bus.ufp_rdata !== 32'hCAFEF00D) $display("FAIL read_rdata_hold got %h exp cafef00d", bus.ufp_rdata); else n_pass++;
  endtask

  task automatic test_miss();
    drive(1'b1, 1'b0, 4'd2, 2'd1, 5'd8, '0, '0, 1'b0, put_word('0, 8, 32'h12345678), 1'b0);
    step();
    n_checks++; if (bus.ufp_resp !== 1'b0) $display("FAIL miss_resp got %b exp 0", bus.ufp_resp); else n_pass++;
    n_checks++; if (bus.ufp_rdata !== 32'hCAFEF00D) $display("FAIL miss_rdata got %h exp cafef00d", bus.ufp_rdata); else n_pass++;
    idle();
  endtask

  task automatic test_write_drain();
    line_t base = put_word('0, 4, 32'h55667788);
    drive(1'b0, 1'b1, 4'd3, 2'd0, 5'd4, 32'h11223344, 4'b0101, 1'b1, base, 1'b0);
    n_checks++; if (bus.arr_we !== 1'b0) $display("FAIL wr_arr_we_empty got %b exp 0", bus.arr_we); else n_pass++;
    step();
    n_checks++; if (bus.ufp_resp !== 1'b1) $display("FAIL wr_resp got %b exp 1", bus.ufp_resp); else n_pass++;
    n_checks++; if (bus.sb_valid !== 1'b1) $display("FAIL wr_sb_valid got %b exp 1", bus.sb_valid); else n_pass++;
    idle();
    n_checks++; if (bus.arr_we !== 1'b1) $display("FAIL wr_drain_we got %b exp 1", bus.arr_we); else n_pass++;
    n_checks++; if (bus.arr_set !== 4'd3) $display("FAIL wr_drain_set got %0d exp 3", bus.arr_set); else n_pass++;
    n_checks++; if (bus.arr_way !== 2'd0) $display("FAIL wr_drain_way got %0d exp 0", bus.arr_way); else n_pass++;
    n_checks++; if (bus.arr_wmask !== 32'h00000050) $display("FAIL wr_drain_mask got %h exp 00000050", bus.arr_wmask); else n_pass++;
    n_checks++; if (bus.arr_wdata[63:32] !== 32'h55227744) $display("FAIL wr_drain_data got %h exp 55227744", bus.arr_wdata[63:32]); else n_pass++;
    step();
    n_checks++; if (bus.sb_valid !== 1'b0) $display("FAIL wr_sb_clear got %b exp 0", bus.sb_valid); else n_pass++;
    n_checks++; if (bus.arr_we !== 1'b0) $display("FAIL wr_we_after got %b exp 0", bus.arr_we); else n_pass++;
  endtask

  task automatic test_zero_mask();
    drive(1'b0, 1'b1, 4'd7, 2'd3, 5'd0, 32'hFFFFFFFF, 4'b0000, 1'b1, '0, 1'b0);
    step();
    n_checks++; if (bus.ufp_resp !== 1'b1) $display("FAIL zmask_resp got %b exp 1", bus.ufp_resp); else n_pass++;
    n_checks++; if (bus.sb_valid !== 1'b0) $display("FAIL zmask_sb_valid got %b exp 0", bus.sb_valid); else n_pass++;
    idle();
  endtask

  task automatic test_forward();
    line_t base = put_word('0, 4, 32'h55667788);
    drive(1'b0, 1'b1, 4'd3, 2'd0, 5'd4, 32'h000000AA, 4'b0001, 1'b1, base, 1'b0);
    step();
    drive(1'b1, 1'b0, 4'd3, 2'd0, 5'd4, '0, '0, 1'b1, base, 1'b0);
    n_checks++; if (bus.arr_we !== 1'b0) $display("FAIL fwd_arr_we got %b exp 0", bus.arr_we); else n_pass++;
    step();
    n_checks++; if (bus.ufp_rdata !== 32'h556677AA) $display("FAIL fwd_rdata got %h exp 556677aa", bus.ufp_rdata); else n_pass++;
    n_checks++; if (bus.sb_valid !== 1'b1) $display("FAIL fwd_sb_kept got %b exp 1", bus.sb_valid); else n_pass++;
    idle();
    n_checks++; if (bus.arr_wmask !== 32'h00000010) $display("FAIL fwd_drain_mask got %h exp 00000010", bus.arr_wmask); else n_pass++;
    step();
    n_checks++; if (bus.sb_valid !== 1'b0) $display("FAIL fwd_sb_clear got %b exp 0", bus.sb_valid); else n_pass++;
  endtask

  task automatic test_read_flush();
    line_t base = put_word('0, 4, 32'h55667788);
    drive(1'b0, 1'b1, 4'd3, 2'd0, 5'd4, 32'h000000BB, 4'b0001, 1'b1, base, 1'b0);
    step();
    drive(1'b1, 1'b0, 4'd3, 2'd0, 5'd4, '0, '0, 1'b1, base, 1'b1);
    n_checks++; if (bus.arr_we !== 1'b1) $display("FAIL flush_we got %b exp 1", bus.arr_we); else n_pass++;
    n_checks++; if (bus.arr_wdata[63:32] !== 32'h556677BB) $display("FAIL flush_data got %h exp 556677bb", bus.arr_wdata[63:32]); else n_pass++;
    step();
    n_checks++; if (bus.ufp_rdata !== 32'h556677BB) $display("FAIL flush_rdata got %h exp 556677bb", bus.ufp_rdata); else n_pass++;
    n_checks++; if (bus.sb_valid !== 1'b0) $display("FAIL flush_sb_clear got %b exp 0", bus.sb_valid); else n_pass++;
    idle();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 4'd3, 2'd0, 5'd0, 32'h01020304, 4'b1111, 1'b1, '0, 1'b0);
    step();
    drive(1'b0, 1'b1, 4'd3, 2'd0, 5'd4, 32'h05060708, 4'b1111, 1'b1, '1, 1'b0);
    n_checks++; if (bus.arr_we !== 1'b0) $display("FAIL b2b_coalesce_we got %b exp 0", bus.arr_we); else n_pass++;
    step();
    idle();
    n_checks++; if (bus.arr_we !== 1'b1) $display("FAIL b2b_drain_we got %b exp 1", bus.arr_we); else n_pass++;
    n_checks++; if (bus.arr_wmask !== 32'h000000FF) $display("FAIL b2b_mask got %h exp 000000ff", bus.arr_wmask); else n_pass++;
    n_checks++; if (bus.arr_wdata[127:0] !== 128'h0000000000000000_05060708_01020304)
      $display("FAIL b2b_data got %h exp 0000000000000000_0506070801020304", bus.arr_wdata[127:0]); else n_pass++;
    step();
    n_checks++; if (bus.sb_valid !== 1'b0) $display("FAIL b2b_sb_clear got %b exp 0", bus.sb_valid); else n_pass++;
  endtask

  task automatic test_reload();
    drive(1'b0, 1'b1, 4'd3, 2'd0, 5'd0, 32'hA1A2A3A4, 4'b1111, 1'b1, '0, 1'b0);
    step();
    drive(1'b0, 1'b1, 4'd5, 2'd2, 5'd8, 32'hB1B2B3B4, 4'b1111, 1'b1, '0, 1'b0);
    n_checks++; if (bus.arr_we !== 1'b1) $display("FAIL reload_old_we got %b exp 1", bus.arr_we); else n_pass++;
    n_checks++; if (bus.arr_set !== 4'd3) $display("FAIL reload_old_set got %0d exp 3", bus.arr_set); else n_pass++;
    n_checks++; if (bus.arr_wmask !== 32'h0000000F) $display("FAIL reload_old_mask got %h exp 0000000f", bus.arr_wmask); else n_pass++;
    n_checks++; if (bus.arr_wdata[31:0] !== 32'hA1A2A3A4) $display("FAIL reload_old_data got %h exp a1a2a3a4", bus.arr_wdata[31:0]); else n_pass++;
    step();
    n_checks++; if (bus.sb_valid !== 1'b1) $display("FAIL reload_sb_valid got %b exp 1", bus.sb_valid); else n_pass++;
    idle();
    n_checks++; if (bus.arr_set !== 4'd5) $display("FAIL reload_new_set got %0d exp 5", bus.arr_set); else n_pass++;
    n_checks++; if (bus.arr_way !== 2'd2) $display("FAIL reload_new_way got %0d exp 2", bus.arr_way); else n_pass++;
    n_checks++; if (bus.arr_wmask !== 32'h00000F00) $display("FAIL reload_new_mask got %h exp 00000f00", bus.arr_wmask); else n_pass++;
    n_checks++; if (bus.arr_wdata[95:64] !== 32'hB1B2B3B4) $display("FAIL reload_new_data got %h exp b1b2b3b4", bus.arr_wdata[95:64]); else n_pass++;
    step();
    n_checks++; if (bus.sb_valid !== 1'b0) $display("FAIL reload_sb_clear got %b exp 0", bus.sb_valid); else n_pass++;
  endtask

  task automatic test_reset_discard();
    drive(1'b0, 1'b1, 4'd3, 2'd0, 5'd4, 32'hCCDDEEFF, 4'b1111, 1'b1, '0, 1'b0);
    step();
    rst = 1'b1;
    idle();
    n_checks++; if (bus.arr_we !== 1'b0) $display("FAIL rstd_we_in_reset got %b exp 0", bus.arr_we); else n_pass++;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.sb_valid !== 1'b0) $display("FAIL rstd_sb_valid got %b exp 0", bus.sb_valid); else n_pass++;
    n_checks++; if (bus.ufp_resp !== 1'b0) $display("FAIL rstd_resp got %b exp 0", bus.ufp_resp); else n_pass++;
    n_checks++; if (bus.arr_we !== 1'b0) $display("FAIL rstd_we_after got %b exp 0", bus.arr_we); else n_pass++;
    step();
    n_checks++; if (bus.arr_we !== 1'b0) $display("FAIL rstd_we_later got %b exp 0", bus.arr_we); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    test_reset();
    test_read_hit();
    test_miss();
    test_write_drain();
    test_zero_mask();
    test_forward();
    test_read_flush();
    test_back_to_back();
    test_reload();
    test_reset_discard();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_data_stage.md
Name: cache_data_stage

Overview:
- Registered successor to the combinational cache data handler. Serves read and write hits on a WAYS-way set-associative data array with a parametrised line and word width.
- Write hits are merged into a one-entry store buffer and drained to the array on a later cycle. Read hits see buffered bytes through forwarding.
- Sits between the cache controller FSM and the data SRAM array. The controller uses sb_valid and flush_req to drain the buffer before miss refill and writeback.

Parameters:
- WAYS, 4, associativity.
- SET_WIDTH, 4, set index bits.
- DATA_WIDTH, 256, line width in bits.
- WORD_WIDTH, 32, request word width in bits.
- OFFSET_WIDTH, 5, byte offset bits; must equal log2(DATA_WIDTH/8).
- MASK_WIDTH, DATA_WIDTH/8, line byte-mask width (derived).
- WMASK_WIDTH, WORD_WIDTH/8, request byte-mask width (derived).
- WAY_WIDTH, $clog2(WAYS), way index bits (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_read  in  1  read request this cycle
- req_write  in  1  write request this cycle
- req_set  in  SET_WIDTH  set index
- req_way  in  WAY_WIDTH  hit way
- req_offset  in  OFFSET_WIDTH  byte offset in line
- req_wmask  in  WMASK_WIDTH  request byte enables
- req_wdata  in  WORD_WIDTH  store data
- hit  in  1  tag hit for req_set/req_way
- cache_data  in  DATA_WIDTH  array line read for req_set/req_way
- flush_req  in  1  force buffer drain
- ufp_resp  out  1  registered response
- ufp_rdata  out  WORD_WIDTH  registered read data
- arr_we  out  1  array write enable
- arr_set  out  SET_WIDTH  array write set
- arr_way  out  WAY_WIDTH  array write way
- arr_wmask  out  MASK_WIDTH  array byte enables
- arr_wdata  out  DATA_WIDTH  array write line
- sb_valid  out  1  store buffer occupied

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- On reset: sb_valid=0, ufp_resp=0, ufp_rdata=0, arr_we=0. A store held in the buffer when reset asserts is discarded.
- Word alignment: aligned offset = req_offset with the low log2(WMASK_WIDTH) bits cleared. Misaligned low bits are ignored.
- Accepted request: (req_read|req_write) && hit. If req_read and req_write are both high, read wins and the write is ignored. A miss produces no response and no buffer change.
- Response latency: exactly 1 cycle. ufp_resp is high the cycle after acceptance, for one cycle only. ufp_rdata holds its value until the next read response.
- Buffer match: sb_valid && sb_set==req_set && sb_way==req_way.
- Read hit: word = cache_data at the aligned offset. On buffer match, each byte whose sb_mask bit is set is replaced by the buffered byte. The result is registered into ufp_rdata.
- Write hit, no buffer match:
  - Buffer captures set, way, and cache_data with req_wdata bytes merged at the aligned offset.
  - sb_mask = req_wmask shifted to the aligned byte position.
  - sb_valid=1.
- Write hit with buffer match (coalesce): new bytes are merged onto the buffered line (not onto cache_data). sb_mask |= shifted req_wmask.
- Write with req_wmask=0: still responds; buffer state is unchanged.
- Drain, combinational: arr_we = sb_valid && (!req_read || flush_req) && !coalesce.
  - arr_set, arr_way, arr_wdata and arr_wmask come from the buffer; arr_wmask = sb_mask.
  - Buffer contents drive arr_* while arr_we=0.
- After drain, sb_valid clears, except when the same cycle captures a new non-matching write: old entry drains and new entry loads, sb_valid stays 1.
- Read and flush_req in the same cycle: drain happens and the read is still served with forwarding from the pre-drain buffer.
- A pure flush_req cycle with an empty buffer has no effect.

Decomposition:
- Package cache_pkg holds:
  - line, word and mask typedefs from DATA_WIDTH/WORD_WIDTH;
  - a store-buffer entry struct {valid, set, way, line, mask};
  - helper function word_align(offset).
- One sub-module, line_byte_merge (combinational): merges a WORD_WIDTH word under a byte mask into a line at an aligned offset, and also produces the shifted line mask. It is used for both capture and coalesce.

Test Plan:
- Reset, then read hit set=2, way=1, offset=8, cache_data word[8..11]=0xDEADBEEF -> cycle+1 ufp_resp=1, ufp_rdata=0xDEADBEEF; arr_we=0 throughout.
- Write hit set=3, way=0, offset=4, wdata=0x11223344, wmask=0b0101, then an idle cycle -> cycle+1 ufp_resp=1 and sb_valid=1. Idle cycle: arr_we=1, arr_set=3, arr_wmask bits 4 and 6 only, line bytes 4=0x44 and 6=0x22. Next cycle sb_valid=0.
- Write hit (3,0,offset 4, 0x000000AA, wmask 0001), then read hit (3,0,offset 4) with array still holding 0x55667788 -> ufp_rdata=0x556677AA (forwarded); arr_we=0 during the read.
- Two back-to-back writes to (3,0), offsets 0 and 4, full masks, then idle -> single drain with arr_wmask=0x000000FF.
- Write to (3,0), then write to (5,2) next cycle -> arr_we=1 for (3,0) in the second cycle and the buffer reloads with set 5; sb_valid stays 1.
- Buffered write, then rst high for 1 cycle -> sb_valid=0, ufp_resp=0, arr_we=0, and no array write ever occurs.
